fetch_queue: RTL and testbench

Instruction fetch queue on the consumer side of the PC stream. The fetch stage pushes 8-byte fetch packets: a PC plus two 32-bit LA64 instructions with a per-slot valid mask. The queue buffers them in a FIFO and presents one packet per cycle to decode over a valid/ready handshake. It also checks that the accepted PC stream advances by 8, supports pipeline flush on redirect, and raises a sticky error on a sequence break.

---
 rtl/fetch_queue_pkg.sv | 12 +
 rtl/fetch_queue_if.sv | 38 +++
 rtl/fetch_queue_mem.sv | 28 ++
 rtl/fetch_queue.sv | 116 +++++++++++
 tb/tb_fetch_queue.sv | 154 +++++++++++++++
 5 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared LA64 front-end constants for the fetch queue and its users.
// Latency: n/a (constants only).
// Backpressure: n/a.
package fetch_queue_pkg;

  localparam int LA64_PC_WIDTH   = 64;
  localparam int LA64_INST_WIDTH = 32;
  // Instruction slots per fetch packet.
  localparam int FETCH_WIDTH     = 2;
  localparam logic [LA64_PC_WIDTH-1:0] DEFAULT_PC = 64'h0000_0000_1C00_0000;

endpackage : fetch_queue_pkg

// File: rtl/fetch_queue_if.sv
// Fetch-packet write port, decode read port, flush and status of the fetch queue.
// Latency: n/a (wires only).
// Backpressure: o_wr_ready gates writes, i_rd_ready gates reads.
// Modports: master = fetch/decode side driving i_*, slave = the queue driving o_*.
interface fetch_queue_if #(
  parameter int PC_WIDTH   = 64,
  parameter int INST_WIDTH = 32,
  parameter int DEPTH      = 8
);
  logic                       i_flush;
  logic                       i_wr_valid;
  logic                       o_wr_ready;
  logic [PC_WIDTH-1:0]        i_wr_pc;
  logic [INST_WIDTH-1:0]      i_wr_inst0;
  logic [INST_WIDTH-1:0]      i_wr_inst1;
  logic [1:0]                 i_wr_mask;
  logic                       o_rd_valid;
  logic                       i_rd_ready;
  logic [PC_WIDTH-1:0]        o_rd_pc;
  logic [INST_WIDTH-1:0]      o_rd_inst0;
  logic [INST_WIDTH-1:0]      o_rd_inst1;
  logic [1:0]                 o_rd_mask;
  logic [$clog2(DEPTH):0]     o_count;
  logic                       o_seq_err;

  modport master (
    output i_flush, i_wr_valid, i_wr_pc, i_wr_inst0, i_wr_inst1, i_wr_mask, i_rd_ready,
    input  o_wr_ready, o_rd_valid, o_rd_pc, o_rd_inst0, o_rd_inst1, o_rd_mask,
           o_count, o_seq_err
  );

  modport slave (
    input  i_flush, i_wr_valid, i_wr_pc, i_wr_inst0, i_wr_inst1, i_wr_mask, i_rd_ready,
    output o_wr_ready, o_rd_valid, o_rd_pc, o_rd_inst0, o_rd_inst1, o_rd_mask,
           o_count, o_seq_err
  );

endinterface : fetch_queue_if

// File: rtl/fetch_queue_mem.sv
// Packet storage: DEPTH x DW register array, synchronous write, asynchronous read.
// Latency: write visible on the read port the cycle after the write edge.
// Backpressure: none; the caller guarantees the write slot is free.
// Ports: clk, wr_en/wr_addr/wr_dat write port, rd_addr/rd_dat read port. Data is not reset.
module fetch_queue_mem #(
  parameter int DEPTH = 8,
  parameter int DW    = 130,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_dat,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_dat
);

  logic [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_dat;
    end
  end

  assign rd_dat = mem_q[rd_addr];

endmodule : fetch_queue_mem

// File: rtl/fetch_queue.sv
// Fetch packet FIFO between fetch and decode with PC-sequence checking and flush.
// Latency: 1 cycle write-to-read, no empty bypass; one push and one pop per cycle.
// Backpressure: o_wr_ready low only when full (independent of i_rd_ready); flush masks o_rd_valid.
// Ports: clk, rst_n (async active-low), fq (slave side of fetch_queue_if).
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int PC_WIDTH   = LA64_PC_WIDTH,
  parameter int INST_WIDTH = LA64_INST_WIDTH,
  parameter int DEPTH      = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_queue_if.slave  fq
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = PC_WIDTH + FETCH_WIDTH * INST_WIDTH + FETCH_WIDTH;
  // Byte span of one packet; consecutive packets must advance by this much.
  localparam logic [PC_WIDTH-1:0] PC_STEP = PC_WIDTH'(FETCH_WIDTH * INST_WIDTH / 8);
  localparam logic [CW-1:0]       FULL    = CW'(DEPTH);

  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic [PC_WIDTH-1:0] exp_pc_q, exp_pc_d;
  logic                have_exp_q, have_exp_d;
  logic                seq_err_q, seq_err_d;

  logic                wr_ready;
  logic                rd_valid;
  logic                push;
  logic                pop;
  logic [DW-1:0]       wr_dat;
  logic [DW-1:0]       rd_dat;

  // Ready comes from registered count only, so a full queue refuses even while popping.
  assign wr_ready = (count_q != FULL);
  assign rd_valid = (count_q != '0) && !fq.i_flush;
  assign push     = fq.i_wr_valid && wr_ready && !fq.i_flush;
  assign pop      = rd_valid && fq.i_rd_ready;

  assign wr_dat = {fq.i_wr_pc, fq.i_wr_inst1, fq.i_wr_inst0, fq.i_wr_mask};

  fetch_queue_mem #(
    .DEPTH (DEPTH),
    .DW    (DW),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push),
    .wr_addr (wr_ptr_q),
    .wr_dat  (wr_dat),
    .rd_addr (rd_ptr_q),
    .rd_dat  (rd_dat)
  );

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    exp_pc_d   = exp_pc_q;
    have_exp_d = have_exp_q;
    seq_err_d  = seq_err_q;

    if (fq.i_flush) begin
      // Redirect: empty the queue and restart the sequence check; the error stays sticky.
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      have_exp_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      if (push) begin
        if (have_exp_q && (fq.i_wr_pc != exp_pc_q)) seq_err_d = 1'b1;
        exp_pc_d   = fq.i_wr_pc + PC_STEP;
        have_exp_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      exp_pc_q   <= '0;
      have_exp_q <= 1'b0;
      seq_err_q  <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      exp_pc_q   <= exp_pc_d;
      have_exp_q <= have_exp_d;
      seq_err_q  <= seq_err_d;
    end
  end

  assign fq.o_wr_ready = wr_ready;
  assign fq.o_rd_valid = rd_valid;
  assign fq.o_rd_pc    = rd_dat[DW-1 -: PC_WIDTH];
  assign fq.o_rd_inst1 = rd_dat[2 + 2*INST_WIDTH - 1 -: INST_WIDTH];
  assign fq.o_rd_inst0 = rd_dat[2 + INST_WIDTH - 1 -: INST_WIDTH];
  assign fq.o_rd_mask  = rd_dat[1:0];
  assign fq.o_count    = count_q;
  assign fq.o_seq_err  = seq_err_q;

endmodule : fetch_queue

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: per-cycle vector table plus hand sequences for async reset.
// Latency: n/a. Backpressure: driven by the vectors (i_rd_ready held low to fill).
// Instruction words and mask are derived from the PC so the head is checkable from its PC alone.
module tb_fetch_queue;

  localparam int PW = 64;
  localparam int IW = 32;
  localparam int D  = 8;

  logic clk;
  logic rst_n;

  fetch_queue_if #(.PC_WIDTH(PW), .INST_WIDTH(IW), .DEPTH(D)) fq ();

  fetch_queue #(.PC_WIDTH(PW), .INST_WIDTH(IW), .DEPTH(D)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .fq    (fq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          flush;
    logic          wv;
    logic [PW-1:0] pc;
    logic          rr;
    logic          e_rdy;
    logic          e_rv;
    logic [3:0]    e_cnt;
    logic          e_err;
    logic [PW-1:0] e_pc;
  } vec_t;

  vec_t tbl[$];
  int   n_vec;
  int   n_bad;

  function automatic vec_t mk(logic flush, logic wv, logic [PW-1:0] pc, logic rr,
                              logic e_rdy, logic e_rv, logic [3:0] e_cnt, logic e_err,
                              logic [PW-1:0] e_pc);
    vec_t v;
    v.flush = flush; v.wv = wv; v.pc = pc; v.rr = rr;
    v.e_rdy = e_rdy; v.e_rv = e_rv; v.e_cnt = e_cnt; v.e_err = e_err; v.e_pc = e_pc;
    return v;
  endfunction

  task automatic drive(logic flush, logic wv, logic [PW-1:0] pc, logic rr);
    fq.i_flush    = flush;
    fq.i_wr_valid = wv;
    fq.i_wr_pc    = pc;
    fq.i_wr_inst0 = ~pc[31:0];
    fq.i_wr_inst1 = pc[31:0] ^ 32'h1234_5678;
    fq.i_wr_mask  = pc[4:3];
    fq.i_rd_ready = rr;
  endtask

  task automatic check(string nm, logic e_rdy, logic e_rv, logic [3:0] e_cnt, logic e_err,
                       logic [PW-1:0] e_pc);
    logic ok;
    ok = (fq.o_wr_ready === e_rdy) && (fq.o_rd_valid === e_rv) &&
         (fq.o_count === e_cnt) && (fq.o_seq_err === e_err);
    if (e_rv) begin
      ok = ok && (fq.o_rd_pc === e_pc) && (fq.o_rd_inst0 === ~e_pc[31:0]) &&
           (fq.o_rd_inst1 === (e_pc[31:0] ^ 32'h1234_5678)) && (fq.o_rd_mask === e_pc[4:3]);
    end
    n_vec++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: got rdy=%b rv=%b cnt=%0d err=%b pc=%h i0=%h i1=%h m=%b; want rdy=%b rv=%b cnt=%0d err=%b pc=%h",
               nm, fq.o_wr_ready, fq.o_rd_valid, fq.o_count, fq.o_seq_err, fq.o_rd_pc,
               fq.o_rd_inst0, fq.o_rd_inst1, fq.o_rd_mask, e_rdy, e_rv, e_cnt, e_err, e_pc);
    end
  endtask

  localparam logic [PW-1:0] B = 64'h1C00_0000;

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, '0, 1'b0);

    // Each entry: inputs held for one cycle, expected outputs seen before that cycle's edge.
    // Fill to 8 with no reads; first packet has mask 00.
    for (int k = 0; k < 8; k++)
      tbl.push_back(mk(0, 1, B + 64'(8*k), 0, 1, (k != 0), 4'(k), 0, B));
    // Full: offered 9th refused, even while a pop happens alongside.
    tbl.push_back(mk(0, 1, B + 64'h40, 0, 0, 1, 4'd8, 0, B));
    tbl.push_back(mk(0, 1, B + 64'h40, 1, 0, 1, 4'd8, 0, B));
    // Drain the rest in order.
    for (int k = 1; k < 8; k++)
      tbl.push_back(mk(0, 0, '0, 1, 1, 1, 4'(8 - k), 0, B + 64'(8*k)));
    tbl.push_back(mk(0, 0, '0, 0, 1, 0, 4'd0, 0, '0));
    // Refill to 4 with pointers wrapped around, then stream push+pop for 20 cycles.
    for (int k = 0; k < 4; k++)
      tbl.push_back(mk(0, 1, B + 64'h40 + 64'(8*k), 0, 1, (k != 0), 4'(k), 0, B + 64'h40));
    for (int k = 0; k < 20; k++)
      tbl.push_back(mk(0, 1, B + 64'h60 + 64'(8*k), 1, 1, 1, 4'd4, 0, B + 64'h40 + 64'(8*k)));
    // Fifth entry, then flush with a colliding write of 0x2000.
    tbl.push_back(mk(0, 1, B + 64'h100, 0, 1, 1, 4'd4, 0, B + 64'hE0));
    tbl.push_back(mk(1, 1, 64'h2000, 1, 1, 0, 4'd5, 0, '0));
    tbl.push_back(mk(0, 1, 64'h8000, 0, 1, 0, 4'd0, 0, '0));
    tbl.push_back(mk(0, 0, '0, 1, 1, 1, 4'd1, 0, 64'h8000));
    // Flush to restart checking, then a sequence break 0x1C000000 -> 0x1C000010.
    tbl.push_back(mk(1, 0, '0, 0, 1, 0, 4'd0, 0, '0));
    tbl.push_back(mk(0, 1, B, 0, 1, 0, 4'd0, 0, '0));
    tbl.push_back(mk(0, 1, B + 64'h10, 0, 1, 1, 4'd1, 0, B));
    tbl.push_back(mk(0, 0, '0, 0, 1, 1, 4'd2, 1, B));
    tbl.push_back(mk(1, 0, '0, 0, 1, 0, 4'd2, 1, '0));
    tbl.push_back(mk(0, 0, '0, 0, 1, 0, 4'd0, 1, '0));

    #12;
    check("reset", 1'b1, 1'b0, 4'd0, 1'b0, '0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].flush, tbl[i].wv, tbl[i].pc, tbl[i].rr);
      #1;
      check($sformatf("vec%0d", i), tbl[i].e_rdy, tbl[i].e_rv, tbl[i].e_cnt,
            tbl[i].e_err, tbl[i].e_pc);
    end

    // Async reset with three entries queued: outputs clear before any clock edge.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(1'b0, 1'b1, 64'h4000 + 64'(8*k), 1'b0);
    end
    @(negedge clk);
    drive(1'b0, 1'b0, '0, 1'b0);
    #1;
    check("pre_rst", 1'b1, 1'b1, 4'd3, 1'b1, 64'h4000);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst", 1'b1, 1'b0, 4'd0, 1'b0, '0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 1'b1, 64'h9000, 1'b0);
    #1;
    check("rst_release", 1'b1, 1'b0, 4'd0, 1'b0, '0);
    @(negedge clk);
    drive(1'b0, 1'b0, '0, 1'b0);
    #1;
    check("post_rst_push", 1'b1, 1'b1, 4'd1, 1'b0, 64'h9000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule : tb_fetch_queue
